// File: rtl/enc_word_loader_pkg.sv
// Shared definitions for the AES-128 word loader front-end.
// Holds the loader state encoding, the block width and the word-width legality check.
// No logic; imported by the loader, its shift register and anything else that needs the state names.
package enc_pkg;

   localparam int BLK_W       = 128;
   localparam int TIMEOUT_MIN = 20;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      LOAD_KEY = 3'd1,
      LOAD_PT  = 3'd2,
      START    = 3'd3,
      WAIT     = 3'd4,
      DRAIN    = 3'd5
   } loader_state_t;

   // Only widths that split 128 into at least two whole words are supported.
   function automatic bit word_w_legal(input int w);
      return (w == 8) || (w == 32) || (w == 64);
   endfunction

endpackage

// File: rtl/enc_word_loader_if.sv
// Word-stream bundle between the loader and its neighbours: plaintext/key words in, ciphertext words out.
// Pure wiring, no latency.
// Both directions are valid/ready; a word moves only when valid and ready are high in the same cycle.
// Ports: in_valid/in_ready/in_data/in_key (input stream + key sideband), out_valid/out_ready/out_data (output stream).
interface enc_word_loader_if #(
   parameter int WORD_W = 32
);
   logic              in_valid;
   logic              in_ready;
   logic [WORD_W-1:0] in_data;
   logic              in_key;
   logic              out_valid;
   logic              out_ready;
   logic [WORD_W-1:0] out_data;

   // master: the neighbour that feeds words in and takes ciphertext out
   modport master (
      output in_valid, in_data, in_key, out_ready,
      input  in_ready, out_valid, out_data
   );

   // slave: the loader itself
   modport slave (
      input  in_valid, in_data, in_key, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/enc_word_loader_word_shift_reg.sv
// 128-bit register that shifts words in at the bottom and presents the oldest word at the top.
// One-cycle update; parallel load takes priority over shift.
// No flow control of its own; the owner decides when load/shift fire.
// Ports: clk, rst, load+pin (parallel load), shift+din (shift one word in), q (full register).
module word_shift_reg
   import enc_pkg::*;
#(
   parameter int WORD_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              shift,
   input  logic [WORD_W-1:0] din,
   input  logic [BLK_W-1:0]  pin,
   output logic [BLK_W-1:0]  q
);

   // Shifting left means the first word shifted in ends up in the most
   // significant slot once the whole block has arrived, and on the way out
   // the top word is always the next one to send.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else if (load) begin
         q <= pin;
      end else if (shift) begin
         q <= {q[BLK_W-WORD_W-1:0], din};
      end
   end

endmodule

// File: rtl/enc_word_loader.sv
// Loads key/plaintext words into AES-128 core inputs, runs one block, streams the ciphertext back out.
// Block cost: NW load (plus NW key) cycles, 1 start cycle, core latency, NW drain cycles.
// in_ready is low from START through DRAIN; out_data holds while out_ready is low.
// Ports: clk, rst, bus (word streams, slave side), enc_start/enc_key/enc_pt/enc_done/enc_ct (core), busy, err.
module enc_word_loader
   import enc_pkg::*;
#(
   parameter int WORD_W      = 32,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic               clk,
   input  logic               rst,
   enc_word_loader_if.slave   bus,
   output logic               enc_start,
   output logic [BLK_W-1:0]   enc_key,
   output logic [BLK_W-1:0]   enc_pt,
   input  logic               enc_done,
   input  logic [BLK_W-1:0]   enc_ct,
   output logic               busy,
   output logic               err
);

   localparam int NW = BLK_W / WORD_W;
   localparam int CW = $clog2(NW);
   localparam int TW = $clog2(TIMEOUT_CYC);

   generate
      if (!word_w_legal(WORD_W)) begin : g_bad_word_w
         $error("enc_word_loader: WORD_W must be 8, 32 or 64");
      end
      if (TIMEOUT_CYC < TIMEOUT_MIN) begin : g_bad_timeout
         $error("enc_word_loader: TIMEOUT_CYC must be at least 20");
      end
   endgenerate

   loader_state_t    state;
   logic [CW-1:0]    wcnt;
   logic [TW-1:0]    tcnt;
   logic             hs_in;
   logic             hs_out;
   logic             last_word;
   logic             timeout;
   logic             key_shift;
   logic             pt_shift;
   logic             ct_load;
   logic [BLK_W-1:0] ct_q;

   assign hs_in     = bus.in_valid & bus.in_ready;
   assign hs_out    = bus.out_valid & bus.out_ready;
   assign last_word = (wcnt == CW'(NW - 1));

   // A done in the final WAIT cycle takes precedence over the timeout.
   assign timeout   = (state == WAIT) && !enc_done && (tcnt == TW'(TIMEOUT_CYC - 1));

   // The sideband only matters on the first word; after that the state decides.
   assign key_shift = hs_in && ((state == LOAD_KEY) || ((state == IDLE) &&  bus.in_key));
   assign pt_shift  = hs_in && ((state == LOAD_PT)  || ((state == IDLE) && !bus.in_key));
   assign ct_load   = (state == WAIT) && enc_done;

   assign bus.in_ready  = (state == IDLE) || (state == LOAD_KEY) || (state == LOAD_PT);
   assign bus.out_valid = (state == DRAIN);
   assign bus.out_data  = ct_q[BLK_W-1 -: WORD_W];
   assign enc_start     = (state == START) || (state == WAIT);
   assign busy          = (state != IDLE);
   assign err           = timeout;

   // Key and plaintext registers feed the core directly; they only move
   // while words are being accepted, so they are frozen during START/WAIT.
   word_shift_reg #(.WORD_W(WORD_W)) u_key (
      .clk   (clk),
      .rst   (rst),
      .load  (1'b0),
      .shift (key_shift),
      .din   (bus.in_data),
      .pin   ('0),
      .q     (enc_key)
   );

   word_shift_reg #(.WORD_W(WORD_W)) u_pt (
      .clk   (clk),
      .rst   (rst),
      .load  (1'b0),
      .shift (pt_shift),
      .din   (bus.in_data),
      .pin   ('0),
      .q     (enc_pt)
   );

   word_shift_reg #(.WORD_W(WORD_W)) u_ct (
      .clk   (clk),
      .rst   (rst),
      .load  (ct_load),
      .shift (hs_out),
      .din   ('0),
      .pin   (enc_ct),
      .q     (ct_q)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         wcnt  <= '0;
         tcnt  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (hs_in) begin
                  wcnt  <= CW'(1);
                  state <= bus.in_key ? LOAD_KEY : LOAD_PT;
               end
            end
            LOAD_KEY: begin
               if (hs_in) begin
                  if (last_word) begin
                     wcnt  <= '0;
                     state <= LOAD_PT;
                  end else begin
                     wcnt <= wcnt + CW'(1);
                  end
               end
            end
            LOAD_PT: begin
               if (hs_in) begin
                  if (last_word) begin
                     wcnt  <= '0;
                     state <= START;
                  end else begin
                     wcnt <= wcnt + CW'(1);
                  end
               end
            end
            START: begin
               tcnt  <= '0;
               state <= WAIT;
            end
            WAIT: begin
               if (enc_done) begin
                  wcnt  <= '0;
                  state <= DRAIN;
               end else if (timeout) begin
                  // Plaintext is abandoned; the key register is left alone
                  // so the next plaintext-only block can reuse it.
                  state <= IDLE;
               end else begin
                  tcnt <= tcnt + TW'(1);
               end
            end
            DRAIN: begin
               if (hs_out) begin
                  if (last_word) begin
                     wcnt  <= '0;
                     state <= IDLE;
                  end else begin
                     wcnt <= wcnt + CW'(1);
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_enc_word_loader.sv
module tb_enc_word_loader;

   localparam int TIMEOUT = 64;
   localparam int LAT     = 10;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   enc_word_loader_if #(.WORD_W(32)) if32();
   enc_word_loader_if #(.WORD_W(8))  if8();

   logic         e_start0, e_start1, done0, done1, busy0, busy1, err0, err1;
   logic [127:0] e_key0, e_key1, e_pt0, e_pt1, ct0, ct1;

   enc_word_loader #(.WORD_W(32), .TIMEOUT_CYC(TIMEOUT)) dut32 (
      .clk(clk), .rst(rst), .bus(if32),
      .enc_start(e_start0), .enc_key(e_key0), .enc_pt(e_pt0),
      .enc_done(done0), .enc_ct(ct0), .busy(busy0), .err(err0)
   );

   enc_word_loader #(.WORD_W(8), .TIMEOUT_CYC(TIMEOUT)) dut8 (
      .clk(clk), .rst(rst), .bus(if8),
      .enc_start(e_start1), .enc_key(e_key1), .enc_pt(e_pt1),
      .enc_done(done1), .enc_ct(ct1), .busy(busy1), .err(err1)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- AES-128 reference ----------------
   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] sq, r;
      sq = x;
      r  = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq = gmul(sq, sq);
         r  = gmul(r, sq);
      end
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [127:0] aes128(input logic [127:0] key, input logic [127:0] pt);
      logic [31:0]  w[44];
      logic [7:0]   s[16];
      logic [7:0]   t[16];
      logic [7:0]   rc, a0, a1, a2, a3;
      logic [31:0]  tmp;
      logic [127:0] res;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {sbox(tmp[31:24]), sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0])} ^ {rc, 24'h0};
            rc  = xt(rc);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++) t[i] = sbox(s[i]);
         for (int row = 0; row < 4; row++)
            for (int col = 0; col < 4; col++)
               s[row+4*col] = t[row+4*((col+row)%4)];
         if (r < 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
               s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
               s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
               s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
               s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
         end
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r+i/4][31-8*(i%4) -: 8];
      end
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
      return res;
   endfunction

   // ---------------- core model ----------------
   int core_cnt[2];
   bit core_hang[2];
   bit stray_req;

   task automatic core_step(input int d, input logic st, input logic [127:0] k, input logic [127:0] p,
                            inout logic dn, inout logic [127:0] ct);
      if (dn) begin
         dn = 1'b0;
      end else if (d == 0 && stray_req) begin
         dn = 1'b1;
         ct = '1;
         stray_req = 1'b0;
      end else if (st && !core_hang[d]) begin
         core_cnt[d]++;
         if (core_cnt[d] >= LAT) begin
            dn = 1'b1;
            ct = aes128(k, p);
            core_cnt[d] = 0;
         end
      end else begin
         core_cnt[d] = 0;
      end
   endtask

   initial begin
      done0 = 1'b0; done1 = 1'b0; ct0 = '0; ct1 = '0;
      forever begin
         @(negedge clk);
         core_step(0, e_start0, e_key0, e_pt0, done0, ct0);
         core_step(1, e_start1, e_key1, e_pt1, done1, ct1);
      end
   end

   // ---------------- scoreboard / monitors ----------------
   typedef struct packed {
      logic [127:0] key;
      logic [127:0] pt;
   } start_t;

   logic [31:0] exp_q[$];
   logic [7:0]  exp8_q[$];
   start_t      start_q[$];

   initial begin
      logic        prev_st;
      logic        stalled;
      logic [31:0] held;
      start_t      se;
      prev_st = 1'b0;
      stalled = 1'b0;
      held    = '0;
      forever begin
         @(negedge clk);
         #1;
         if (rst) begin
            prev_st = 1'b0;
            stalled = 1'b0;
            continue;
         end
         if (e_start0 && !prev_st) begin
            if (start_q.size() == 0) begin
               chk("unexpected_start", 128'(1), 128'(0));
            end else begin
               se = start_q.pop_front();
               chk("enc_key_at_start", e_key0, se.key);
               chk("enc_pt_at_start", e_pt0, se.pt);
            end
         end
         prev_st = e_start0;
         if (stalled) begin
            chk("hold_valid", 128'(if32.out_valid), 128'(1));
            chk("hold_data", 128'(if32.out_data), 128'(held));
         end
         if (if32.out_valid) chk("in_ready_low_in_drain", 128'(if32.in_ready), 128'(0));
         if (if32.out_valid && if32.out_ready) begin
            if (exp_q.size() == 0) chk("unexpected_out_word", 128'(if32.out_data), 128'(0) - 128'(1));
            else                   chk("ct_word32", 128'(if32.out_data), 128'(exp_q.pop_front()));
         end
         stalled = if32.out_valid && !if32.out_ready;
         held    = if32.out_data;
         if (if8.out_valid && if8.out_ready) begin
            if (exp8_q.size() == 0) chk("unexpected_out_byte", 128'(if8.out_data), 128'(0) - 128'(1));
            else                    chk("ct_byte8", 128'(if8.out_data), 128'(exp8_q.pop_front()));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "watchdog");
   end

   // ---------------- drivers ----------------
   task automatic push_word32(input logic [31:0] w, input bit k);
      int g = 0;
      if32.in_valid = 1'b1;
      if32.in_data  = w;
      if32.in_key   = k;
      while (!if32.in_ready && g < 200) begin
         @(negedge clk);
         g++;
      end
      if (g >= 200) chk("in_ready_budget32", 128'(0), 128'(1));
      @(negedge clk);
      if32.in_valid = 1'b0;
   endtask

   task automatic push_word8(input logic [7:0] w, input bit k);
      int g = 0;
      if8.in_valid = 1'b1;
      if8.in_data  = w;
      if8.in_key   = k;
      while (!if8.in_ready && g < 200) begin
         @(negedge clk);
         g++;
      end
      if (g >= 200) chk("in_ready_budget8", 128'(0), 128'(1));
      @(negedge clk);
      if8.in_valid = 1'b0;
   endtask

   // Returns on the negedge right after the last plaintext word is taken,
   // which must be the START cycle.
   task automatic send32(input bit k, input logic [127:0] key, input logic [127:0] pt);
      if (k) for (int i = 0; i < 4; i++) push_word32(key[127-32*i -: 32], k);
      for (int i = 0; i < 4; i++) push_word32(pt[127-32*i -: 32], k);
      chk("start_after_load", 128'(e_start0), 128'(1));
   endtask

   task automatic wait_idle32();
      int g = 0;
      while ((busy0 || exp_q.size() != 0) && g < 600) begin
         @(negedge clk);
         g++;
      end
      chk("block_done_in_budget", 128'(g < 600), 128'(1));
   endtask

   typedef struct {
      bit           in_key;
      logic [127:0] key;     // key expected on enc_key (new or retained)
      logic [127:0] pt;
      logic [127:0] exp_ct;
   } vec_t;

   task automatic apply_row(input vec_t v);
      start_t se;
      if32.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) exp_q.push_back(v.exp_ct[127-32*i -: 32]);
      se.key = v.key;
      se.pt  = v.pt;
      start_q.push_back(se);
      send32(v.in_key, v.key, v.pt);
      wait_idle32();
   endtask

   localparam logic [127:0] FIPS_K  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] FIPS_P  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] FIPS_C  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] K2      = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] P2      = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C2      = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   vec_t tbl[5];

   initial begin
      start_t     se;
      vec_t       v;
      int         k;
      int         g;
      bit         pat[4];
      logic [127:0] ptx;

      rst = 1'b1;
      if32.in_valid = 1'b0; if32.in_data = '0; if32.in_key = 1'b0; if32.out_ready = 1'b1;
      if8.in_valid  = 1'b0; if8.in_data  = '0; if8.in_key  = 1'b0; if8.out_ready  = 1'b1;
      core_hang[0] = 1'b0; core_hang[1] = 1'b0; stray_req = 1'b0;
      core_cnt[0] = 0; core_cnt[1] = 0;

      tbl[0] = '{1'b1, FIPS_K, FIPS_P, FIPS_C};
      tbl[1] = '{1'b0, FIPS_K, P2, aes128(FIPS_K, P2)};
      tbl[2] = '{1'b1, K2, P2, C2};
      tbl[3] = '{1'b0, K2, FIPS_P, aes128(K2, FIPS_P)};
      tbl[4] = '{1'b0, K2, 128'hffffffff_00000000_a5a5a5a5_5a5a5a5a, aes128(K2, 128'hffffffff_00000000_a5a5a5a5_5a5a5a5a)};

      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_in_ready", 128'(if32.in_ready), 128'(1));
      chk("rst_out_valid", 128'(if32.out_valid), 128'(0));
      chk("rst_enc_start", 128'(e_start0), 128'(0));
      chk("rst_busy", 128'(busy0), 128'(0));
      chk("rst_err", 128'(err0), 128'(0));
      chk("rst_enc_key", e_key0, 128'(0));
      @(negedge clk);

      // table-driven blocks: new key, reused key, second key, reuse, reuse
      for (int r = 0; r < 5; r++) apply_row(tbl[r]);

      // backpressure 1,0,0,1 during drain
      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
      ptx = 128'hdeadbeef_01234567_89abcdef_cafef00d;
      if32.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) exp_q.push_back(aes128(K2, ptx) >> (96 - 32*i));
      se.key = K2; se.pt = ptx; start_q.push_back(se);
      send32(1'b0, K2, ptx);
      g = 0;
      while (!if32.out_valid && g < 200) begin @(negedge clk); g++; end
      chk("drain_reached", 128'(if32.out_valid), 128'(1));
      for (int i = 0; i < 4; i++) begin
         if32.out_ready = pat[i];
         @(negedge clk);
      end
      if32.out_ready = 1'b1;
      g = 0;
      while (if32.out_valid && g < 50) begin @(negedge clk); g++; end
      chk("in_ready_after_drain", 128'(if32.in_ready), 128'(1));
      chk("all_words_drained", 128'(exp_q.size()), 128'(0));

      // timeout: core never answers
      core_hang[0] = 1'b1;
      ptx = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
      se.key = K2; se.pt = ptx; start_q.push_back(se);
      send32(1'b0, K2, ptx);
      k = 0;
      while (k < 200) begin
         @(negedge clk);
         k++;
         if (err0) break;
      end
      chk("timeout_wait_cycle", 128'(k - 1), 128'(TIMEOUT - 1));
      @(negedge clk);
      chk("timeout_start_low", 128'(e_start0), 128'(0));
      chk("timeout_idle", 128'(busy0), 128'(0));
      chk("timeout_err_pulse", 128'(err0), 128'(0));
      core_hang[0] = 1'b0;
      v = '{1'b0, K2, P2, C2};
      apply_row(v);

      // reset five cycles after START
      core_hang[0] = 1'b1;
      se.key = K2; se.pt = FIPS_P; start_q.push_back(se);
      send32(1'b0, K2, FIPS_P);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_mid_enc_start", 128'(e_start0), 128'(0));
      chk("rst_mid_busy", 128'(busy0), 128'(0));
      chk("rst_mid_out_valid", 128'(if32.out_valid), 128'(0));
      @(negedge clk);
      rst = 1'b0;
      core_hang[0] = 1'b0;
      stray_req = 1'b1;
      g = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (if32.out_valid || busy0) g++;
      end
      chk("stray_done_ignored", 128'(g), 128'(0));
      chk("key_cleared_by_rst", e_key0, 128'(0));
      v = '{1'b0, 128'(0), P2, aes128(128'(0), P2)};
      apply_row(v);

      // byte-wide loader, FIPS-197 vector
      for (int i = 0; i < 16; i++) exp8_q.push_back(FIPS_C[127-8*i -: 8]);
      for (int i = 0; i < 16; i++) push_word8(FIPS_K[127-8*i -: 8], 1'b1);
      for (int i = 0; i < 16; i++) push_word8(FIPS_P[127-8*i -: 8], 1'b1);
      chk("w8_start", 128'(e_start1), 128'(1));
      chk("w8_enc_key", e_key1, FIPS_K);
      chk("w8_enc_pt", e_pt1, FIPS_P);
      g = 0;
      while ((busy1 || exp8_q.size() != 0) && g < 600) begin @(negedge clk); g++; end
      chk("w8_done_in_budget", 128'(g < 600), 128'(1));

      chk("scoreboard_empty", 128'(exp_q.size() + start_q.size()), 128'(0));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/enc_word_loader.md
Name: enc_word_loader

Overview:
- Front-end stage directly upstream of the AES-128 encrypt core.
- Assembles a 128-bit key and a 128-bit plaintext block from a narrow valid/ready word stream, then drives the core's start/plaintext/key inputs and waits for its done pulse.
- Captures the 128-bit ciphertext and returns it as a word stream.
- Holds the key between blocks so a stream of plaintexts under one key costs only plaintext words.

Parameters:
- WORD_W, 32: input/output word width; legal values 8, 32, 64. NW = 128/WORD_W is a derived localparam.
- TIMEOUT_CYC, 64: maximum cycles in WAIT before an error abort; minimum legal value 20.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input word valid
- in_ready  out  1  input word accepted when in_valid & in_ready
- in_data  in  WORD_W  input word
- in_key  in  1  sideband, sampled with the first word of a transaction: 1 = key words (NW) precede plaintext words (NW); 0 = plaintext only, retained key reused
- out_valid  out  1  ciphertext word valid
- out_ready  in  1  downstream accepts ciphertext word
- out_data  out  WORD_W  ciphertext word
- enc_start  out  1  to core E_int; level, held high until enc_done
- enc_key  out  128  to core key; stable while enc_start high
- enc_pt  out  128  to core plaintext; stable while enc_start high
- enc_done  in  1  core E_done single-cycle pulse
- enc_ct  in  128  core ciphertext; valid in the enc_done cycle
- busy  out  1  high in any state other than IDLE
- err  out  1  one-cycle pulse on WAIT timeout

Behaviour:
- Reset values: all registers 0, state IDLE, in_ready=1, out_valid=0, enc_start=0, busy=0, err=0, key register 0.
- Word order: the first word received fills bits [127:128-WORD_W], most significant first. Output uses the same order. No byte reversal here; the core handles endianness.
- FSM states: IDLE, LOAD_KEY, LOAD_PT, START, WAIT, DRAIN.
- IDLE:
  - in_ready=1.
  - On handshake with in_key=1: store word 0 of key, set wcnt=1, go to LOAD_KEY.
  - On handshake with in_key=0: store word 0 of plaintext, set wcnt=1, go to LOAD_PT.
  - NW=1 is not legal (WORD_W ≤ 64).
- LOAD_KEY:
  - in_ready=1; each handshake stores a word and increments wcnt.
  - When the word at wcnt=NW-1 is accepted: set wcnt=0 and go to LOAD_PT.
  - in_key is ignored after the first word.
- LOAD_PT: same as LOAD_KEY. After the last plaintext word, go to START.
- START: enc_start=1 for one cycle, then go to WAIT. in_ready=0 from START through DRAIN.
- WAIT:
  - enc_start held at 1; timeout counter increments each cycle.
  - On enc_done=1: capture enc_ct into ct_reg, drop enc_start to 0 in the next cycle, go to DRAIN with wcnt=0.
  - If the counter reaches TIMEOUT_CYC-1 without enc_done: pulse err, drop enc_start, go to IDLE, discard the plaintext, keep the key.
  - An enc_done in the same cycle as the timeout wins: no err.
- DRAIN:
  - out_valid=1; out_data = ct_reg word wcnt.
  - wcnt advances only on out_valid & out_ready; out_data stays stable while stalled.
  - After word NW-1 is accepted, go to IDLE.
  - in_ready is not asserted in the last DRAIN cycle; it rises the following cycle.
- enc_done outside WAIT is ignored.
- enc_key and enc_pt are driven straight from the holding registers, which are not written outside LOAD states. This guarantees stability while the core works.
- Mid-operation reset: immediate return to reset values, including deasserting enc_start. The core sees E_int fall.
- Throughput: with in_key=0 and WORD_W=32, block period = 4 load + 1 start + core latency + 4 drain cycles.

Decomposition:
- Shared package enc_pkg holds: the loader_state_t enum (IDLE, LOAD_KEY, LOAD_PT, START, WAIT, DRAIN), localparam BLK_W=128, and the legal-WORD_W check constant.
- One natural sub-module, word_shift_reg: a 128-bit shift-in/shift-out register with load/shift enables. It is instantiated three times (key, plaintext, ciphertext).
- The FSM, counters and timeout logic stay in the top module.

Test Plan:
- FIPS-197 vector (WORD_W=32, key-model core): in_key=1; key words 2b7e1516, 28aed2a6, abf71588, 09cf4f3c; plaintext words 3243f6a8, 885a308d, 313198a2, e0370734. Required: enc_key=2b7e1516...09cf4f3c and enc_pt=3243f6a8...e0370734 at START; out words 3925841d, 02dc09fb, dc118597, 196a0b32.
- Key reuse: second transaction with in_key=0 and plaintext 00112233...ccddeeff. Required: enc_key unchanged and no key words consumed; ciphertext matches the reference model under the retained key.
- Backpressure: out_ready toggled 1,0,0,1 during DRAIN. Required: out_data holds each word while stalled, four words total in order, in_ready stays 0 until the drain completes.
- Timeout: core model never pulses done. Required: err=1 exactly at WAIT cycle TIMEOUT_CYC-1 (63), enc_start=0 the next cycle, state IDLE; a following in_key=0 block uses the retained key.
- Reset mid-WAIT: assert rst for 1 cycle 5 cycles after START. Required: enc_start, busy, out_valid = 0 immediately; a later enc_done pulse is ignored; out_valid stays 0.
- WORD_W=8: 16 key bytes plus 16 plaintext bytes of the FIPS-197 vector. Required: 16 output bytes 39, 25, 84, 1d, ... 0b, 32.
